ddr2_cmd_monitor: RTL and testbench

Device-side receiver for the DDR2 command bus driven by the controller. Each cycle it samples {cs_n, ras_n, cas_n, we_n}, bank address and row/column address, and decodes the sampled command into a ddr2_cmd_t. It tracks per-bank state (bank_state_t), open row and timing counters, and flags protocol and timing violations. It sits between the controller PHY outputs and the memory model or bench, and serves as the checker for every controller test.

---
 rtl/ddr2_cmd_monitor_pkg.sv | 65 ++++++
 rtl/ddr2_bank_fsm.sv | 106 ++++++++++
 rtl/ddr2_cmd_monitor.sv | 198 +++++++++++++++++++
 tb/tb_ddr2_cmd_monitor.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_cmd_monitor_pkg.sv
// ddr2_cmd_monitor_pkg
//   Shared types, timing constants and the command decode helper for the
//   DDR2 command-bus monitor.
//   - ddr2_cmd_t   : decoded command, encoded as {ras_n, cas_n, we_n} when cs_n=0
//   - bank_state_t : per-bank protocol state
//   - ddr2_err_t   : violation codes; a lower code has higher priority
//   - tRCD..tREFI  : default timing values in clock cycles
package ddr2_cmd_monitor_pkg;

   typedef enum logic [3:0] {
      CMD_MRS = 4'd0,
      CMD_REF = 4'd1,
      CMD_PRE = 4'd2,
      CMD_ACT = 4'd3,
      CMD_WR  = 4'd4,
      CMD_RD  = 4'd5,
      CMD_ILL = 4'd6,
      CMD_NOP = 4'd7,
      CMD_DES = 4'd8
   } ddr2_cmd_t;

   typedef enum logic [2:0] {
      BANK_IDLE       = 3'd0,
      BANK_ACTIVATING = 3'd1,
      BANK_ACTIVE     = 3'd2,
      BANK_READING    = 3'd3,
      BANK_WRITING    = 3'd4,
      BANK_PRECHARGE  = 3'd5
   } bank_state_t;

   typedef enum logic [3:0] {
      ERR_NONE     = 4'd0,
      ERR_ILLEGAL  = 4'd1,
      ERR_ACT_OPEN = 4'd2,
      ERR_TRC      = 4'd3,
      ERR_TRRD     = 4'd4,
      ERR_TRCD     = 4'd5,
      ERR_CLOSED   = 4'd6,
      ERR_TRAS     = 4'd7,
      ERR_REF_BUSY = 4'd8,
      ERR_MRS_BUSY = 4'd9,
      ERR_TCCD     = 4'd10
   } ddr2_err_t;

   localparam int tRCD  = 15;
   localparam int tRP   = 15;
   localparam int tRAS  = 40;
   localparam int tRC   = 55;
   localparam int tRRD  = 10;
   localparam int tCCD  = 2;
   localparam int tREFI = 3120;

   // Width of the timing down-counters; must hold the largest T-1.
   localparam int CNT_W = 8;

   // {cs_n, ras_n, cas_n, we_n} -> command. cs_n high deselects regardless
   // of the other lines; otherwise the low three bits are the encoding.
   function automatic ddr2_cmd_t ddr2_decode_cmd(input logic [3:0] pins);
      if (pins[3]) begin
         return CMD_DES;
      end
      return ddr2_cmd_t'({1'b0, pins[2:0]});
   endfunction

endpackage

// File: rtl/ddr2_bank_fsm.sv
// ddr2_bank_fsm
//   State tracker for a single DDR2 bank: bank state, open row and the
//   rcd / ras / rc / rp / ccd down-counters. The parent decides which
//   commands target this bank; this block applies them and exposes the
//   flags the parent needs to classify violations.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     act             ACT targets this bank (row latched from row)
//     rdwr, is_wr     RD/WR targets this bank (already filtered for CLOSED)
//     pre             PRE covers this bank (single or all-banks)
//     row             address bus
//     state           current bank_state_t
//     open_row        row latched by the last ACT
//     idle, activating, closed, rc_busy, tras_viol, ccd_busy  violation flags
module ddr2_bank_fsm
   import ddr2_cmd_monitor_pkg::*;
#(
   parameter int ROW_W = 14,
   parameter int T_RCD = tRCD,
   parameter int T_RAS = tRAS,
   parameter int T_RC  = tRC,
   parameter int T_RP  = tRP,
   parameter int T_CCD = tCCD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              act,
   input  logic              rdwr,
   input  logic              is_wr,
   input  logic              pre,
   input  logic [ROW_W-1:0]  row,
   output bank_state_t       state,
   output logic [ROW_W-1:0]  open_row,
   output logic              idle,
   output logic              activating,
   output logic              closed,
   output logic              rc_busy,
   output logic              tras_viol,
   output logic              ccd_busy
);

   bank_state_t      state_reg;
   logic [ROW_W-1:0] open_row_reg;
   logic [CNT_W-1:0] rcd_reg, ras_reg, rc_reg, rp_reg, ccd_reg;
   logic             is_open;

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

   assign is_open = (state_reg == BANK_ACTIVATING) || (state_reg == BANK_ACTIVE) ||
                    (state_reg == BANK_READING)    || (state_reg == BANK_WRITING);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= BANK_IDLE;
         open_row_reg <= '0;
         rcd_reg      <= '0;
         ras_reg      <= '0;
         rc_reg       <= '0;
         rp_reg       <= '0;
         ccd_reg      <= '0;
      end else begin
         rcd_reg <= dec_sat(rcd_reg);
         ras_reg <= dec_sat(ras_reg);
         rc_reg  <= dec_sat(rc_reg);
         rp_reg  <= dec_sat(rp_reg);
         ccd_reg <= dec_sat(ccd_reg);

         // Timed transitions fire on the edge where the counter reaches 0,
         // so the new state is visible in the first cycle the counter reads 0.
         case (state_reg)
            BANK_ACTIVATING: if (rcd_reg < CNT_W'(2)) state_reg <= BANK_ACTIVE;
            BANK_READING,
            BANK_WRITING:    if (ccd_reg < CNT_W'(2)) state_reg <= BANK_ACTIVE;
            BANK_PRECHARGE:  if (rp_reg  < CNT_W'(2)) state_reg <= BANK_IDLE;
            default: ;
         endcase

         // A command this cycle overrides any timed transition.
         if (act) begin
            state_reg    <= BANK_ACTIVATING;
            open_row_reg <= row;
            rcd_reg      <= CNT_W'(T_RCD - 1);
            ras_reg      <= CNT_W'(T_RAS - 1);
            rc_reg       <= CNT_W'(T_RC - 1);
         end else if (rdwr) begin
            state_reg <= is_wr ? BANK_WRITING : BANK_READING;
            ccd_reg   <= CNT_W'(T_CCD - 1);
         end else if (pre && is_open) begin
            state_reg <= BANK_PRECHARGE;
            rp_reg    <= CNT_W'(T_RP - 1);
         end
      end
   end

   assign state      = state_reg;
   assign open_row   = open_row_reg;
   assign idle       = (state_reg == BANK_IDLE);
   assign activating = (state_reg == BANK_ACTIVATING);
   assign closed     = (state_reg == BANK_IDLE) || (state_reg == BANK_PRECHARGE);
   assign rc_busy    = (rc_reg != '0);
   assign tras_viol  = is_open && (ras_reg != '0);
   assign ccd_busy   = (ccd_reg != '0);

endmodule

// File: rtl/ddr2_cmd_monitor.sv
// ddr2_cmd_monitor
//   Device-side DDR2 command-bus checker. Decodes {cs_n,ras_n,cas_n,we_n},
//   tracks every bank through ddr2_bank_fsm instances, and reports the
//   highest-priority (lowest-code) protocol/timing violation per cycle.
//   Optional macro DDR2_REFI_CHECK_EN builds the refresh-interval counter
//   and the REFI_LIMIT parameter; otherwise refi_overdue is tied low.
//   Ports:
//     clk, rst_n                        clock, synchronous active-low reset
//     cmd_in, ba_in, addr_in            sampled command bus
//     dec_valid/cmd/bank/addr/a10       registered decode of non-NOP/DES commands
//     bank_state, open_row              packed per-bank state, bank 0 in LSBs
//     err_valid/code/bank, err_cnt      registered violation report and count
//     refi_overdue                      refresh interval exceeded (level)
module ddr2_cmd_monitor
   import ddr2_cmd_monitor_pkg::*;
#(
   parameter int NUM_BANKS  = 8,
   parameter int ROW_W      = 14,
   parameter int T_RCD      = tRCD,
   parameter int T_RP       = tRP,
   parameter int T_RAS      = tRAS,
   parameter int T_RC       = tRC,
   parameter int T_RRD      = tRRD,
   parameter int T_CCD      = tCCD,
`ifdef DDR2_REFI_CHECK_EN
   parameter int REFI_LIMIT = 9 * tREFI,
`endif
   localparam int BA_W      = $clog2(NUM_BANKS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3:0]               cmd_in,
   input  logic [BA_W-1:0]          ba_in,
   input  logic [ROW_W-1:0]         addr_in,
   output logic                     dec_valid,
   output logic [3:0]               dec_cmd,
   output logic [BA_W-1:0]          dec_bank,
   output logic [ROW_W-1:0]         dec_addr,
   output logic                     dec_a10,
   output logic [3*NUM_BANKS-1:0]   bank_state,
   output logic [ROW_W*NUM_BANKS-1:0] open_row,
   output logic                     err_valid,
   output logic [3:0]               err_code,
   output logic [BA_W-1:0]          err_bank,
   output logic [15:0]              err_cnt,
   output logic                     refi_overdue
);

   ddr2_cmd_t cmd;
   logic      is_cmd;
   logic      is_rdwr;

   assign cmd     = ddr2_decode_cmd(cmd_in);
   assign is_cmd  = (cmd != CMD_NOP) && (cmd != CMD_DES);
   assign is_rdwr = (cmd == CMD_RD) || (cmd == CMD_WR);

   logic [NUM_BANKS-1:0] hit, act_sel, rdwr_sel, pre_sel;
   logic [NUM_BANKS-1:0] idle_v, activating_v, closed_v, rc_busy_v, tras_v, ccd_busy_v;

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      bank_state_t st;

      assign hit[gi]      = (ba_in == BA_W'(gi));
      assign act_sel[gi]  = (cmd == CMD_ACT) && hit[gi];
      // RD/WR to a closed bank is reported but must not move the bank.
      assign rdwr_sel[gi] = is_rdwr && hit[gi] && !closed_v[gi];
      assign pre_sel[gi]  = (cmd == CMD_PRE) && (addr_in[10] || hit[gi]);

      ddr2_bank_fsm #(
         .ROW_W (ROW_W),
         .T_RCD (T_RCD),
         .T_RAS (T_RAS),
         .T_RC  (T_RC),
         .T_RP  (T_RP),
         .T_CCD (T_CCD)
      ) u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .act        (act_sel[gi]),
         .rdwr       (rdwr_sel[gi]),
         .is_wr      (cmd == CMD_WR),
         .pre        (pre_sel[gi]),
         .row        (addr_in),
         .state      (st),
         .open_row   (open_row[gi*ROW_W +: ROW_W]),
         .idle       (idle_v[gi]),
         .activating (activating_v[gi]),
         .closed     (closed_v[gi]),
         .rc_busy    (rc_busy_v[gi]),
         .tras_viol  (tras_v[gi]),
         .ccd_busy   (ccd_busy_v[gi])
      );

      assign bank_state[gi*3 +: 3] = st;
   end

   // Global ACT-to-ACT spacing counter.
   logic [CNT_W-1:0] rrd_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rrd_reg <= '0;
      end else if (cmd == CMD_ACT) begin
         rrd_reg <= CNT_W'(T_RRD - 1);
      end else if (rrd_reg != '0) begin
         rrd_reg <= rrd_reg - 1'b1;
      end
   end

   // Priority encoder: within each command the checks are ordered by code,
   // so the first match is the lowest code.
   ddr2_err_t       err_next;
   logic [BA_W-1:0] err_bank_next;

   always_comb begin
      err_next      = ERR_NONE;
      err_bank_next = ba_in;
      case (cmd)
         CMD_ILL: err_next = ERR_ILLEGAL;
         CMD_ACT: begin
            if (!idle_v[ba_in])          err_next = ERR_ACT_OPEN;
            else if (rc_busy_v[ba_in])   err_next = ERR_TRC;
            else if (rrd_reg != '0)      err_next = ERR_TRRD;
         end
         CMD_RD, CMD_WR: begin
            if (activating_v[ba_in])     err_next = ERR_TRCD;
            else if (closed_v[ba_in])    err_next = ERR_CLOSED;
            else if (|ccd_busy_v)        err_next = ERR_TCCD;
         end
         CMD_PRE: begin
            if (addr_in[10]) begin
               // Scan downward so the lowest offending bank is reported.
               for (int i = NUM_BANKS - 1; i >= 0; i--) begin
                  if (tras_v[i]) begin
                     err_next      = ERR_TRAS;
                     err_bank_next = BA_W'(i);
                  end
               end
            end else if (tras_v[ba_in]) begin
               err_next = ERR_TRAS;
            end
         end
         CMD_REF: if (!(&idle_v)) err_next = ERR_REF_BUSY;
         CMD_MRS: if (!(&idle_v)) err_next = ERR_MRS_BUSY;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_valid <= 1'b0;
         dec_cmd   <= '0;
         dec_bank  <= '0;
         dec_addr  <= '0;
         dec_a10   <= 1'b0;
         err_valid <= 1'b0;
         err_code  <= '0;
         err_bank  <= '0;
         err_cnt   <= '0;
      end else begin
         dec_valid <= is_cmd;
         if (is_cmd) begin
            dec_cmd  <= cmd;
            dec_bank <= ba_in;
            dec_addr <= addr_in;
            dec_a10  <= addr_in[10];
         end
         err_valid <= (err_next != ERR_NONE);
         err_code  <= err_next;
         if (err_next != ERR_NONE) begin
            err_bank <= err_bank_next;
            if (err_cnt != 16'hFFFF) begin
               err_cnt <= err_cnt + 16'd1;
            end
         end
      end
   end

`ifdef DDR2_REFI_CHECK_EN
   localparam int REFI_W = $clog2(REFI_LIMIT + 1);
   logic [REFI_W-1:0] refi_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refi_reg <= '0;
      end else if (cmd == CMD_REF) begin
         refi_reg <= '0;
      end else if (refi_reg != REFI_W'(REFI_LIMIT)) begin
         refi_reg <= refi_reg + 1'b1;
      end
   end

   assign refi_overdue = (refi_reg == REFI_W'(REFI_LIMIT));
`else
   assign refi_overdue = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_cmd_monitor.sv
// tb_ddr2_cmd_monitor
//   Directed bench for ddr2_cmd_monitor. Each command pushes its expected
//   decode/error record onto a scoreboard queue; the record is popped and
//   compared one cycle later when the registered outputs appear.
module tb_ddr2_cmd_monitor;
    import ddr2_cmd_monitor_pkg::*;

    localparam int NB = 8;
    localparam int RW = 14;
    localparam int BW = 3;

    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_BAD = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_DES = 4'b1010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [3:0]          cmd_in;
    logic [BW-1:0]       ba_in;
    logic [RW-1:0]       addr_in;
    logic                dec_valid;
    logic [3:0]          dec_cmd;
    logic [BW-1:0]       dec_bank;
    logic [RW-1:0]       dec_addr;
    logic                dec_a10;
    logic [3*NB-1:0]     bank_state;
    logic [RW*NB-1:0]    open_row;
    logic                err_valid;
    logic [3:0]          err_code;
    logic [BW-1:0]       err_bank;
    logic [15:0]         err_cnt;
    logic                refi_overdue;

`ifdef DDR2_REFI_CHECK_EN
    ddr2_cmd_monitor #(.REFI_LIMIT(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in       (cmd_in),
        .ba_in        (ba_in),
        .addr_in      (addr_in),
        .dec_valid    (dec_valid),
        .dec_cmd      (dec_cmd),
        .dec_bank     (dec_bank),
        .dec_addr     (dec_addr),
        .dec_a10      (dec_a10),
        .bank_state   (bank_state),
        .open_row     (open_row),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_bank     (err_bank),
        .err_cnt      (err_cnt),
        .refi_overdue (refi_overdue)
    );
`else
    ddr2_cmd_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_in       (cmd_in),
        .ba_in        (ba_in),
        .addr_in      (addr_in),
        .dec_valid    (dec_valid),
        .dec_cmd      (dec_cmd),
        .dec_bank     (dec_bank),
        .dec_addr     (dec_addr),
        .dec_a10      (dec_a10),
        .bank_state   (bank_state),
        .open_row     (open_row),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_bank     (err_bank),
        .err_cnt      (err_cnt),
        .refi_overdue (refi_overdue)
    );
`endif

    typedef struct packed {
        logic [3:0]    cmd;
        logic [BW-1:0] bank;
        logic [RW-1:0] addr;
        logic [3:0]    err;
        logic [BW-1:0] ebank;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] bs(input int b);
        return bank_state[b*3 +: 3];
    endfunction

    function automatic logic [RW-1:0] orow(input int b);
        return open_row[b*RW +: RW];
    endfunction

    task automatic issue(input string tag, input logic [3:0] c, input int b,
                         input logic [RW-1:0] a, input ddr2_cmd_t ec,
                         input int err, input int eb);
        exp_t e;
        e.cmd   = ec;
        e.bank  = BW'(b);
        e.addr  = a;
        e.err   = 4'(err);
        e.ebank = BW'(eb);
        sb.push_back(e);
        cmd_in  = c;
        ba_in   = BW'(b);
        addr_in = a;
        @(posedge clk);
        #1;
        cmd_in  = C_NOP;
        e = sb.pop_front();
        $display("cmd %s: pins=%b ba=%0d addr=%h -> dec_cmd=%0d err_code=%0d err_bank=%0d",
                 tag, c, b, a, dec_cmd, err_code, err_bank);
        chk({tag, ".dec_valid"}, 32'(dec_valid), 32'd1);
        chk({tag, ".dec_cmd"},   32'(dec_cmd),   32'(e.cmd));
        chk({tag, ".dec_bank"},  32'(dec_bank),  32'(e.bank));
        chk({tag, ".dec_addr"},  32'(dec_addr),  32'(e.addr));
        chk({tag, ".dec_a10"},   32'(dec_a10),   32'(e.addr[10]));
        chk({tag, ".err_valid"}, 32'(err_valid), 32'(e.err != 4'd0));
        chk({tag, ".err_code"},  32'(err_code),  32'(e.err));
        if (e.err != 4'd0) begin
            chk({tag, ".err_bank"}, 32'(err_bank), 32'(e.ebank));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_in = C_NOP;
            @(posedge clk);
            #1;
            chk("idle.dec_valid", 32'(dec_valid), 32'd0);
            chk("idle.err_valid", 32'(err_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        cmd_in = C_NOP;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        cmd_in  = C_NOP;
        ba_in   = '0;
        addr_in = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst.dec_valid",    32'(dec_valid), 32'd0);
        chk("rst.dec_cmd",      32'(dec_cmd),   32'd0);
        chk("rst.bank_state",   32'(bank_state), 32'd0);
        chk("rst.open_row0",    32'(orow(0)), 32'd0);
        chk("rst.open_row7",    32'(orow(7)), 32'd0);
        chk("rst.err_valid",    32'(err_valid), 32'd0);
        chk("rst.err_code",     32'(err_code), 32'd0);
        chk("rst.err_cnt",      32'(err_cnt), 32'd0);
        chk("rst.refi_overdue", 32'(refi_overdue), 32'd0);
        rst_n = 1'b1;

        issue("act_b0", C_ACT, 0, 14'h123, CMD_ACT, 0, 0);
        chk("b0.activating", 32'(bs(0)), 32'(BANK_ACTIVATING));
        chk("b0.open_row", 32'(orow(0)), 32'h123);
        idle(14);
        chk("b0.active_at_15", 32'(bs(0)), 32'(BANK_ACTIVE));
        issue("rd_b0_t15", C_RD, 0, 14'h010, CMD_RD, 0, 0);
        chk("b0.reading", 32'(bs(0)), 32'(BANK_READING));
        issue("rd_b0_tccd", C_RD, 0, 14'h020, CMD_RD, 10, 0);
        idle(1);
        chk("b0.active_after_ccd", 32'(bs(0)), 32'(BANK_ACTIVE));
        issue("wr_b0_ap", C_WR, 0, 14'h430, CMD_WR, 0, 0);
        chk("b0.writing", 32'(bs(0)), 32'(BANK_WRITING));

        do_reset();
        issue("act_b0_b", C_ACT, 0, 14'h123, CMD_ACT, 0, 0);
        idle(13);
        chk("b0.activating_at_14", 32'(bs(0)), 32'(BANK_ACTIVATING));
        issue("rd_b0_t14", C_RD, 0, 14'h008, CMD_RD, 5, 0);
        chk("b0.reading_after_trcd", 32'(bs(0)), 32'(BANK_READING));

        do_reset();
        issue("act_b1", C_ACT, 1, 14'h001, CMD_ACT, 0, 0);
        idle(8);
        issue("act_b2_t9", C_ACT, 2, 14'h002, CMD_ACT, 4, 2);
        do_reset();
        issue("act_b1_b", C_ACT, 1, 14'h001, CMD_ACT, 0, 0);
        idle(9);
        issue("act_b2_t10", C_ACT, 2, 14'h002, CMD_ACT, 0, 0);
        chk("b2.activating", 32'(bs(2)), 32'(BANK_ACTIVATING));
        issue("act_b2_open", C_ACT, 2, 14'h055, CMD_ACT, 2, 2);
        chk("b2.open_row_relatched", 32'(orow(2)), 32'h055);

        do_reset();
        issue("act_b3", C_ACT, 3, 14'h003, CMD_ACT, 0, 0);
        idle(38);
        issue("pre_b3_t39", C_PRE, 3, 14'h000, CMD_PRE, 7, 3);
        chk("b3.precharge", 32'(bs(3)), 32'(BANK_PRECHARGE));
        idle(13);
        chk("b3.precharge_at_14", 32'(bs(3)), 32'(BANK_PRECHARGE));
        idle(1);
        chk("b3.idle_at_15", 32'(bs(3)), 32'(BANK_IDLE));
        issue("act_b3_t54", C_ACT, 3, 14'h004, CMD_ACT, 3, 3);

        do_reset();
        issue("act_b0_c", C_ACT, 0, 14'h100, CMD_ACT, 0, 0);
        idle(9);
        issue("act_b1_c", C_ACT, 1, 14'h101, CMD_ACT, 0, 0);
        idle(9);
        issue("act_b2_c", C_ACT, 2, 14'h102, CMD_ACT, 0, 0);
        idle(39);
        issue("pre_all_t60", C_PRE, 0, 14'h400, CMD_PRE, 0, 0);
        chk("pa.b0", 32'(bs(0)), 32'(BANK_PRECHARGE));
        chk("pa.b1", 32'(bs(1)), 32'(BANK_PRECHARGE));
        chk("pa.b2", 32'(bs(2)), 32'(BANK_PRECHARGE));
        chk("pa.b3", 32'(bs(3)), 32'(BANK_IDLE));
        idle(5);
        issue("ref_t66", C_REF, 0, 14'h000, CMD_REF, 8, 0);
        idle(8);
        issue("ref_t75", C_REF, 0, 14'h000, CMD_REF, 0, 0);
        chk("ref.all_idle", 32'(bank_state), 32'd0);

        do_reset();
        issue("act_b6", C_ACT, 6, 14'h006, CMD_ACT, 0, 0);
        idle(9);
        issue("act_b5", C_ACT, 5, 14'h005, CMD_ACT, 0, 0);
        idle(4);
        issue("pre_all_tras", C_PRE, 7, 14'h400, CMD_PRE, 7, 5);
        chk("pat.b5", 32'(bs(5)), 32'(BANK_PRECHARGE));
        chk("pat.b6", 32'(bs(6)), 32'(BANK_PRECHARGE));
        issue("pre_b7_idle", C_PRE, 7, 14'h000, CMD_PRE, 0, 0);
        chk("pat.b7", 32'(bs(7)), 32'(BANK_IDLE));

        do_reset();
        issue("rd_b4_idle", C_RD, 4, 14'h044, CMD_RD, 6, 4);
        chk("b4.idle_after_closed", 32'(bs(4)), 32'(BANK_IDLE));
        issue("illegal", C_BAD, 4, 14'h000, CMD_ILL, 1, 4);
        chk("ill.err_cnt", 32'(err_cnt), 32'd2);
        chk("b4.idle_after_ill", 32'(bs(4)), 32'(BANK_IDLE));
        cmd_in = C_DES;
        @(posedge clk);
        #1;
        cmd_in = C_NOP;
        chk("des.dec_valid", 32'(dec_valid), 32'd0);
        issue("mrs_idle", C_MRS, 0, 14'h042, CMD_MRS, 0, 0);
        issue("act_b0_d", C_ACT, 0, 14'h010, CMD_ACT, 0, 0);
        idle(1);
        issue("mrs_busy", C_MRS, 0, 14'h042, CMD_MRS, 9, 0);
        chk("mrs.err_cnt", 32'(err_cnt), 32'd3);

        do_reset();
`ifdef DDR2_REFI_CHECK_EN
        idle(99);
        chk("refi.before_limit", 32'(refi_overdue), 32'd0);
        idle(1);
        chk("refi.at_limit", 32'(refi_overdue), 32'd1);
        issue("ref_clear", C_REF, 0, 14'h000, CMD_REF, 0, 0);
        chk("refi.cleared", 32'(refi_overdue), 32'd0);
`else
        idle(120);
        chk("refi.tied_low", 32'(refi_overdue), 32'd0);
`endif

        do_reset();
        issue("illegal_pre_rst", C_BAD, 0, 14'h000, CMD_ILL, 1, 0);
        issue("act_b7", C_ACT, 7, 14'h3FFF, CMD_ACT, 0, 0);
        cmd_in  = C_ACT;
        ba_in   = 3'd7;
        addr_in = 14'h1234;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmd_in = C_NOP;
        chk("mrst.dec_valid",  32'(dec_valid), 32'd0);
        chk("mrst.dec_cmd",    32'(dec_cmd), 32'd0);
        chk("mrst.dec_addr",   32'(dec_addr), 32'd0);
        chk("mrst.err_valid",  32'(err_valid), 32'd0);
        chk("mrst.err_code",   32'(err_code), 32'd0);
        chk("mrst.err_cnt",    32'(err_cnt), 32'd0);
        chk("mrst.bank_state", 32'(bank_state), 32'd0);
        chk("mrst.open_row7",  32'(orow(7)), 32'd0);
        issue("act_b7_after_rst", C_ACT, 7, 14'h0007, CMD_ACT, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
